// File: rtl/program_sequencer.sv
// Program memory and fetch sequencer feeding the 10-bit processor's Ext/Data bus.
// Optional single-step pause between instructions when STEP_EN is defined.
module program_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 10
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Prog_we,
  input  logic [AW-1:0] Prog_addr,
  input  logic [DW-1:0] Prog_wdata,
  input  logic [AW:0]   Prog_len,
  input  logic          Start,
  input  logic          Ext,
  input  logic          Clr,
`ifdef STEP_EN
  input  logic          Step,
`endif
  output logic [DW-1:0] Data,
  output logic          Proc_en,
  output logic          Busy,
  output logic          Done,
  output logic [AW:0]   PC
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    OPERAND,
    EXEC,
`ifdef STEP_EN
    PAUSE,
`endif
    DONE
  } state_t;

  state_t        state, nxt;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd;
  logic [DW-1:0] hold;
  logic [AW:0]   len;
  logic [AW:0]   pc_inc;
  logic          ld;
  logic          ready;

  assign ready  = (state == IDLE) || (state == DONE);
  assign rd     = mem[PC[AW-1:0]];
  assign pc_inc = PC + 1'b1;
  assign ld     = (rd[DW-1:DW-2] == 2'b00) && (rd[3:0] == 4'b0000);

  always_ff @(posedge Clock) begin
    if (!Reset && ready && Prog_we)
      mem[Prog_addr] <= Prog_wdata;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (Start)
          nxt = (Prog_len == '0) ? DONE : FETCH;
      end
      FETCH: begin
        if (Ext)
          nxt = ld ? OPERAND : EXEC;
      end
      OPERAND: begin
        if (Ext && !Clr)
          nxt = EXEC;
        else if (Ext)
`ifdef STEP_EN
          nxt = PAUSE;
`else
          nxt = (pc_inc >= len) ? DONE : FETCH;
`endif
      end
      EXEC: begin
        if (Clr)
`ifdef STEP_EN
          nxt = PAUSE;
`else
          nxt = (PC >= len) ? DONE : FETCH;
`endif
      end
`ifdef STEP_EN
      PAUSE: begin
        if (Step)
          nxt = (PC >= len) ? DONE : FETCH;
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      PC      <= '0;
      len     <= '0;
      hold    <= '0;
      Proc_en <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state   <= nxt;
      Proc_en <= (nxt == FETCH) || (nxt == OPERAND) || (nxt == EXEC);
`ifdef STEP_EN
      Busy    <= (nxt == FETCH) || (nxt == OPERAND) ||
                 (nxt == EXEC) || (nxt == PAUSE);
`else
      Busy    <= (nxt == FETCH) || (nxt == OPERAND) || (nxt == EXEC);
`endif
      Done    <= (nxt == DONE);
      if (ready && Start) begin
        len <= Prog_len;
        PC  <= '0;
      end
      // every word the processor samples is kept so EXEC can keep driving it
      if (((state == FETCH) || (state == OPERAND)) && Ext) begin
        PC   <= pc_inc;
        hold <= rd;
      end
    end
  end

  always_comb begin
    Data = '0;
    unique case (state)
      FETCH, OPERAND: Data = rd;
      EXEC:           Data = hold;
      default:        Data = '0;
    endcase
  end

endmodule
